// File: rtl/load_store_unit.sv
// Converts CPU byte/half/word loads and stores into word-wide data memory accesses.
// Loads and word stores are zero-latency; sub-word stores take a read-modify-write and stall the CPU for one cycle.
module load_store_unit #(
  parameter int MISALIGN_TRAP = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      load_data,
  output logic             stall,
  output logic             access_err,
  output logic [CNT_W-1:0] rmw_count,
  output logic             dm_read,
  output logic             dm_write,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  input  logic [31:0]      dm_rd
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]  state;
  logic [31:0] lat_addr;
  logic [31:0] lat_word;

  logic        illegal;
  logic        misaligned;
  logic        suppress;
  logic        active;
  logic        sub_word;
  logic [1:0]  off;
  logic [4:0]  sh_amt;
  logic [31:0] word_addr;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] wdata_sh;
  logic [31:0] merged;

  always_comb begin
    illegal    = (req_size == 2'b11);
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    suppress   = illegal || (misaligned && (MISALIGN_TRAP != 0));
    active     = rst_n && (state == IDLE) && req_valid && !suppress;
    sub_word   = (req_size != 2'b10);
    // Untrapped misaligned accesses fall back to the naturally aligned lane
    case (req_size)
      2'b00:   off = req_addr[1:0];
      2'b01:   off = {req_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
    sh_amt    = {off, 3'b000};
    word_addr = {req_addr[31:2], 2'b00};
    lane_data = dm_rd >> sh_amt;
    lane_mask = ((req_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh_amt;
    wdata_sh  = req_wdata << sh_amt;
    merged    = (dm_rd & ~lane_mask) | (wdata_sh & lane_mask);
  end

  always_comb begin
    load_data  = 32'h0;
    stall      = 1'b0;
    dm_read    = 1'b0;
    dm_write   = 1'b0;
    dm_addr    = 32'h0;
    dm_wd      = 32'h0;
    access_err = rst_n && (state == IDLE) && req_valid && suppress;
    if (rst_n && (state == RMW_WR)) begin
      dm_write = 1'b1;
      dm_addr  = lat_addr;
      dm_wd    = lat_word;
    end else if (active) begin
      dm_addr = word_addr;
      if (!req_we) begin
        dm_read = 1'b1;
        case (req_size)
          2'b00:   load_data = {{24{!req_unsigned && lane_data[7]}}, lane_data[7:0]};
          2'b01:   load_data = {{16{!req_unsigned && lane_data[15]}}, lane_data[15:0]};
          default: load_data = lane_data;
        endcase
      end else if (sub_word) begin
        dm_read = 1'b1;
        stall   = 1'b1;
      end else begin
        dm_write = 1'b1;
        dm_wd    = req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_addr  <= 32'h0;
      lat_word  <= 32'h0;
      rmw_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (active && req_we && sub_word) begin
            lat_addr <= word_addr;
            lat_word <= merged;
            state    <= RMW_WR;
          end
        end
        default: begin
          state <= IDLE;
          if (rmw_count != {CNT_W{1'b1}})
            rmw_count <= rmw_count + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-wide memory model, write scoreboard, per-feature tasks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [31:0] load_data, dm_addr, dm_wd, dm_rd;
  logic        stall, access_err, dm_read, dm_write;
  logic [15:0] rmw_count;

  logic [31:0] load_data0, dm_addr0, dm_wd0, dm_rd0;
  logic        stall0, access_err0, dm_read0, dm_write0;
  logic [15:0] rmw_count0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_dat = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGN_TRAP(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_data(load_data), .stall(stall),
    .access_err(access_err), .rmw_count(rmw_count), .dm_read(dm_read),
    .dm_write(dm_write), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  load_store_unit #(.MISALIGN_TRAP(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_data(load_data0), .stall(stall0),
    .access_err(access_err0), .rmw_count(rmw_count0), .dm_read(dm_read0),
    .dm_write(dm_write0), .dm_addr(dm_addr0), .dm_wd(dm_wd0), .dm_rd(dm_rd0)
  );

  // Only the trapping instance owns the memory; the other just reads it
  assign dm_rd  = dm_read  ? mem[dm_addr[11:2]]  : 32'hA5A5_A5A5;
  assign dm_rd0 = dm_read0 ? mem[dm_addr0[11:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr[11:2]] <= pre_dat;
    else if (dm_write) mem[dm_addr[11:2]] <= dm_wd;
  end

  always @(negedge clk) begin
    if (dm_write) begin
      wr_t e;
      tests++;
      if (dm_read) begin
        fails++;
        $display("FAIL strobe_exclusive dm_read=%0b dm_write=%0b required not both 1", dm_read, dm_write);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h required no write", dm_addr, dm_wd);
      end else begin
        e = exp_q.pop_front();
        if (dm_addr !== e.addr || dm_wd !== e.data) begin
          fails++;
          $display("FAIL write_data addr=%h data=%h required addr=%h data=%h", dm_addr, dm_wd, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_addr = addr; pre_dat = data; pre_en = 1'b1;
    ref_mem[addr[11:2]] = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] e;
    int sh;
    e  = ref_mem[addr[11:2]];
    sh = 8 * int'(addr[1:0]);
    if (size == 2'b10) e = wdata;
    else if (size == 2'b00) e[sh +: 8] = wdata[7:0];
    else e[sh +: 16] = wdata[15:0];
    ref_mem[addr[11:2]] = e;
    exp_q.push_back({addr & 32'hFFFF_FFFC, e});
    drive(1'b1, size, 1'b0, addr, wdata);
    @(negedge clk);
    tests++;
    if (stall !== (size != 2'b10)) begin
      fails++;
      $display("FAIL store_stall addr=%h stall=%0b required %0b", addr, stall, size != 2'b10);
    end
    @(posedge clk); #1;
    if (size != 2'b10) begin
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || dm_write !== 1'b1) begin
        fails++;
        $display("FAIL rmw_write_phase addr=%h stall=%0b dm_write=%0b required 0/1", addr, stall, dm_write);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp, input string name);
    drive(1'b0, size, uns, addr, 32'h0);
    @(negedge clk);
    tests++;
    if (load_data !== exp || stall !== 1'b0 || dm_read !== 1'b1) begin
      fails++;
      $display("FAIL %s load_data=%h stall=%0b dm_read=%0b required %h/0/1", name, load_data, stall, dm_read, exp);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_suppressed(input logic we, input logic [1:0] size,
                                  input logic [31:0] addr, input string name);
    drive(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    @(negedge clk);
    tests++;
    if (access_err !== 1'b1 || dm_read !== 1'b0 || dm_write !== 1'b0 ||
        stall !== 1'b0 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL %s err=%0b rd=%0b wr=%0b stall=%0b data=%h required 1/0/0/0/0",
               name, access_err, dm_read, dm_write, stall, load_data);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    #12;
    tests++;
    if (access_err !== 1'b0 || dm_read !== 1'b0 || dm_write !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes err=%0b rd=%0b wr=%0b stall=%0b required all 0", access_err, dm_read, dm_write, stall);
    end
    req_size = 2'b10;
    #1;
    tests++;
    if (dm_addr !== 32'h0 || load_data !== 32'h0 || rmw_count !== 16'h0 || rmw_count0 !== 16'h0 || dm_wd0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_values dm_addr=%h load_data=%h rmw_count=%0d required 0", dm_addr, load_data, rmw_count);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    do_store(32'h10, 2'b10, 32'hDEAD_BEEF);
    do_load(32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, "lw_after_sw");
  endtask

  task automatic test_byte_rmw();
    preload(32'h20, 32'h1122_3344);
    tests++;
    if (rmw_count !== 16'd0) begin
      fails++;
      $display("FAIL rmw_count_before count=%0d required 0", rmw_count);
    end
    do_store(32'h22, 2'b00, 32'h0000_00AA);
    tests++;
    if (mem[8] !== 32'h11AA_3344 || rmw_count !== 16'd1) begin
      fails++;
      $display("FAIL sb_result mem=%h count=%0d required 11aa3344/1", mem[8], rmw_count);
    end
  endtask

  task automatic test_extension();
    preload(32'h30, 32'h80F0_017F);
    do_load(32'h30, 2'b00, 1'b0, 32'h0000_007F, "lb_30");
    do_load(32'h33, 2'b00, 1'b0, 32'hFFFF_FF80, "lb_33");
    do_load(32'h33, 2'b00, 1'b1, 32'h0000_0080, "lbu_33");
    do_load(32'h32, 2'b01, 1'b0, 32'hFFFF_80F0, "lh_32");
    do_load(32'h32, 2'b01, 1'b1, 32'h0000_80F0, "lhu_32");
  endtask

  task automatic test_misalign();
    preload(32'h40, 32'hCAFE_F00D);
    check_suppressed(1'b0, 2'b10, 32'h41, "lw_41_trap");
    check_suppressed(1'b1, 2'b01, 32'h43, "sh_43_trap");
    check_suppressed(1'b0, 2'b11, 32'h40, "illegal_load");
    check_suppressed(1'b1, 2'b11, 32'h40, "illegal_store");
    idle_cycle();
    tests++;
    if (mem[16] !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL misalign_mem_unchanged mem=%h required cafef00d", mem[16]);
    end
  endtask

  task automatic test_misalign_notrap();
    idle_cycle();
    drive(1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
    @(negedge clk);
    tests++;
    if (access_err0 !== 1'b0 || dm_read0 !== 1'b1 || dm_addr0 !== 32'h40 ||
        load_data0 !== 32'hCAFE_F00D || stall0 !== 1'b0 || dm_write0 !== 1'b0) begin
      fails++;
      $display("FAIL lw_41_notrap err=%0b rd=%0b addr=%h data=%h required 0/1/40/cafef00d",
               access_err0, dm_read0, dm_addr0, load_data0);
    end
    tests++;
    if (access_err !== 1'b1) begin
      fails++;
      $display("FAIL lw_41_trap_side err=%0b required 1", access_err);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_rmw();
    preload(32'h50, 32'h1234_5678);
    drive(1'b1, 2'b01, 1'b0, 32'h50, 32'h0000_BEEF);
    @(negedge clk);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL sh_50_stall stall=%0b required 1", stall);
    end
    @(posedge clk); #1;
    tests++;
    if (dm_write !== 1'b1) begin
      fails++;
      $display("FAIL sh_50_rmw_wr dm_write=%0b required 1", dm_write);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (dm_write !== 1'b0 || stall !== 1'b0 || dm_addr !== 32'h0 || dm_wd !== 32'h0 || rmw_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_rmw wr=%0b stall=%0b addr=%h wd=%h count=%0d required 0",
               dm_write, stall, dm_addr, dm_wd, rmw_count);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle();
    tests++;
    if (mem[20] !== 32'h1234_5678) begin
      fails++;
      $display("FAIL reset_mid_rmw_mem mem=%h required 12345678", mem[20]);
    end
    do_load(32'h50, 2'b10, 1'b0, 32'h1234_5678, "lw_50_after_reset");
  endtask

  task automatic test_back_to_back();
    preload(32'h60, 32'h5566_7788);
    preload(32'h64, 32'h0000_0000);
    do_store(32'h60, 2'b00, 32'h0000_00AA);
    do_store(32'h61, 2'b00, 32'h0000_00BB);
    do_store(32'h64, 2'b10, 32'h0102_0304);
    idle_cycle();
    tests++;
    if (mem[24] !== 32'h5566_BBAA || mem[25] !== 32'h0102_0304 || rmw_count !== 16'd2) begin
      fails++;
      $display("FAIL back_to_back mem60=%h mem64=%h count=%0d required 5566bbaa/01020304/2",
               mem[24], mem[25], rmw_count);
    end
    do_load(32'h60, 2'b10, 1'b0, 32'h5566_BBAA, "lw_60_merged");
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte_rmw();
    test_extension();
    test_misalign();
    test_misalign_notrap();
    test_reset_mid_rmw();
    test_back_to_back();
    idle_cycle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
